// File: rtl/vsi_pkg.sv
// Shared defaults, state encoding and slew helper for the VSI duty sequencer.
package vsi_pkg;

  localparam int PERIOD_DEF   = 1000;
  localparam int DW_DEF       = 10;
  localparam int STEP_SS_DEF  = 2;
  localparam int STEP_RUN_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SOFTSTART = 3'd1,
    ST_RUN       = 3'd2,
    ST_STOPPING  = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // Move cur toward tgt by at most step; never passes the target.
  function automatic int unsigned slew_toward(input int unsigned cur,
                                              input int unsigned tgt,
                                              input int unsigned step);
    if (tgt > cur) return ((tgt - cur) > step) ? cur + step : tgt;
    else           return ((cur - tgt) > step) ? cur - step : tgt;
  endfunction

endpackage

// File: rtl/vsi_period_timer.sv
// Free-running PWM period counter; period_tick marks the last count of each period.
module vsi_period_timer #(
  parameter int PERIOD = vsi_pkg::PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic period_tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign period_tick = (cnt == LAST);

endmodule

// File: rtl/vsi_duty_sequencer.sv
// Three-phase duty sequencer: soft-start, run, controlled stop and fault trip,
// slewing the applied duty once per PWM period.
module vsi_duty_sequencer
  import vsi_pkg::*;
#(
  parameter int PERIOD   = vsi_pkg::PERIOD_DEF,
  parameter int DW       = vsi_pkg::DW_DEF,
  parameter int STEP_SS  = vsi_pkg::STEP_SS_DEF,
  parameter int STEP_RUN = vsi_pkg::STEP_RUN_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          fault,
  input  logic          fault_clr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [DW-1:0] cmd_c,
  output logic [DW-1:0] d_a,
  output logic [DW-1:0] d_b,
  output logic [DW-1:0] d_c,
  output logic          en,
  output logic [2:0]    state,
  output logic          period_tick
);

  // cmd handshake: a command is taken on any edge where cmd_valid && cmd_ready;
  // cmd_valid needs no hold-off and cmd_ready does not depend on cmd_valid.

  state_t        st, nxt;
  logic [DW-1:0] tgt_a, tgt_b, tgt_c;
  logic [DW-1:0] eff_a, eff_b, eff_c;
  logic [DW-1:0] nd_a, nd_b, nd_c;
  logic          at_tgt, at_zero;
  int unsigned   step;

  vsi_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .period_tick (period_tick)
  );

  function automatic logic [DW-1:0] sat(input logic [DW-1:0] v);
    return (32'(v) > PERIOD) ? DW'(PERIOD) : v;
  endfunction

  always_comb begin
    step  = (st == ST_RUN) ? STEP_RUN : STEP_SS;
    // Stopping ramps to zero without disturbing the stored targets.
    eff_a = (st == ST_STOPPING) ? '0 : tgt_a;
    eff_b = (st == ST_STOPPING) ? '0 : tgt_b;
    eff_c = (st == ST_STOPPING) ? '0 : tgt_c;
    nd_a  = DW'(slew_toward(32'(d_a), 32'(eff_a), step));
    nd_b  = DW'(slew_toward(32'(d_b), 32'(eff_b), step));
    nd_c  = DW'(slew_toward(32'(d_c), 32'(eff_c), step));
    at_tgt  = (nd_a == tgt_a) && (nd_b == tgt_b) && (nd_c == tgt_c);
    at_zero = (nd_a == '0) && (nd_b == '0) && (nd_c == '0);

    nxt = st;
    case (st)
      ST_IDLE:      if (start && !stop) nxt = ST_SOFTSTART;
      ST_SOFTSTART: if (stop) nxt = ST_STOPPING;
                    else if (period_tick && at_tgt) nxt = ST_RUN;
      ST_RUN:       if (stop) nxt = ST_STOPPING;
      ST_STOPPING:  if (period_tick && at_zero) nxt = ST_IDLE;
      ST_FAULT:     if (fault_clr) nxt = ST_IDLE;
      default:      nxt = ST_FAULT;
    endcase
    if (fault) nxt = ST_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      en        <= 1'b0;
      cmd_ready <= 1'b0;
      tgt_a     <= '0;
      tgt_b     <= '0;
      tgt_c     <= '0;
      d_a       <= '0;
      d_b       <= '0;
      d_c       <= '0;
    end else begin
      st        <= nxt;
      en        <= (nxt == ST_SOFTSTART) || (nxt == ST_RUN) || (nxt == ST_STOPPING);
      cmd_ready <= (nxt == ST_IDLE) || (nxt == ST_SOFTSTART) || (nxt == ST_RUN);
      if (cmd_valid && cmd_ready) begin
        tgt_a <= sat(cmd_a);
        tgt_b <= sat(cmd_b);
        tgt_c <= sat(cmd_c);
      end
      // A trip zeroes the duty immediately; otherwise duty moves only at period ends.
      if (nxt == ST_FAULT || st == ST_IDLE || st == ST_FAULT) begin
        d_a <= '0;
        d_b <= '0;
        d_c <= '0;
      end else if (period_tick) begin
        d_a <= nd_a;
        d_b <= nd_b;
        d_c <= nd_c;
      end
    end
  end

  assign state = st;

endmodule
